// File: rtl/opb_register_bank_if.sv
// OPB slave-side bus bundle for opb_register_bank.
// Bit 0 is the MSB of every OPB vector, so each vector uses ascending [0:N] ranges.
interface opb_register_bank_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank.sv
// OPB slave register bank: C_NUM_REGS 32-bit byte-writable registers.
// The registers are exported flat on user_data_out, with a one-cycle
// user_wr_stb pulse for each register that is updated.
// Every transfer is accepted in IDLE, acknowledged for exactly one cycle in ACK,
// and then held in WAIT until the master drops OPB_select.
// An index beyond C_NUM_REGS is acknowledged with Sl_errAck.
// Optional macro OPB_REGBANK_READBACK_EN: when it is defined, reads return the
// register contents. When it is undefined, reads are acked with Sl_DBus = 0 and
// no read mux is built.
module opb_register_bank #(
  parameter logic [31:0] C_BASEADDR  = 32'h01003800,
  parameter logic [31:0] C_HIGHADDR  = 32'h010038FF,
  parameter int          C_NUM_REGS  = 8,
  parameter logic [31:0] C_RESET_VAL = 32'h00000000,
  parameter              C_FAMILY    = "virtex5"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  opb_register_bank_if.slave         bus,
  output logic [32*C_NUM_REGS-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_wr_stb
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  state_t                   state;
  logic [DATA_W-1:0]        addr_p0;
  logic [DATA_W-1:0]        offset_p0;
  logic [DATA_W-1:0]        wdata_p0;
  logic [29:0]              idx_p0;
  logic                     hit_p0;
  logic                     idx_ok_p0;
  logic                     wr_p0;
  logic [C_NUM_REGS-1:0]    wr_sel_p0;
  logic [32*C_NUM_REGS-1:0] regs_p1;
  logic [DATA_W-1:0]        sl_dbus_p1;
  logic                     ack_p1;
  logic                     err_p1;
  logic [C_NUM_REGS-1:0]    stb_p1;
  logic                     unused_ok;

  // ---- p0: address decode of the request presented this cycle ----
  assign addr_p0   = bus.OPB_ABus;
  assign wdata_p0  = bus.OPB_DBus;
  assign offset_p0 = addr_p0 - C_BASEADDR;
  assign idx_p0    = offset_p0[31:2];
  assign hit_p0    = bus.OPB_select && (addr_p0 >= C_BASEADDR) && (addr_p0 <= C_HIGHADDR);
  assign idx_ok_p0 = ({2'b00, idx_p0} < 32'(C_NUM_REGS));
  assign wr_p0     = (state == IDLE) && hit_p0 && idx_ok_p0 && !bus.OPB_RNW && (|bus.OPB_BE);

  // One-hot select of the register written on this edge; empty unless a real write is accepted
  always_comb begin
    wr_sel_p0 = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (wr_p0 && (idx_p0 == 30'(i))) wr_sel_p0[i] = 1'b1;
    end
  end

  // ---- p1: state committed on the accept edge, visible during ACK ----
  // Register file: byte-enabled writes on the IDLE->ACK edge, reset to C_RESET_VAL
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      regs_p1 <= {C_NUM_REGS{C_RESET_VAL}};
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr_sel_p0[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.OPB_BE[b]) regs_p1[32*i + 8*(3-b) +: 8] <= wdata_p0[8*(3-b) +: 8];
          end
        end
      end
    end
  end

  // Transfer FSM with registered acknowledge, error and strobe outputs
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state  <= IDLE;
      ack_p1 <= 1'b0;
      err_p1 <= 1'b0;
      stb_p1 <= '0;
    end else begin
      ack_p1 <= 1'b0;
      err_p1 <= 1'b0;
      stb_p1 <= '0;
      case (state)
        IDLE: begin
          if (hit_p0) begin
            state  <= ACK;
            ack_p1 <= 1'b1;
            err_p1 <= !idx_ok_p0;
            stb_p1 <= wr_sel_p0;
          end
        end
        ACK:     state <= WAIT;
        WAIT:    if (!bus.OPB_select) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OPB_REGBANK_READBACK_EN
  logic [DATA_W-1:0] rd_data_p0;

  // Read mux over the register file
  always_comb begin
    rd_data_p0 = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx_p0 == 30'(i)) rd_data_p0 = regs_p1[32*i +: 32];
    end
  end

  // Read data is launched on the accept edge and exists only for the ACK cycle
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      sl_dbus_p1 <= '0;
    end else if ((state == IDLE) && hit_p0 && idx_ok_p0 && bus.OPB_RNW) begin
      sl_dbus_p1 <= rd_data_p0;
    end else begin
      sl_dbus_p1 <= '0;
    end
  end
`else
  assign sl_dbus_p1 = '0;
`endif

  assign bus.Sl_DBus    = sl_dbus_p1;
  assign bus.Sl_xferAck = ack_p1;
  assign bus.Sl_errAck  = err_p1;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;
  assign user_data_out  = regs_p1;
  assign user_wr_stb    = stb_p1;

  // seqAddr, the byte-offset address bits and the family name carry no function
  assign unused_ok = &{1'b0, bus.OPB_seqAddr, offset_p0[1:0], ^C_FAMILY};

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed bench for opb_register_bank.
// Each transfer pushes its expected response onto a scoreboard queue, and the
// entry is popped and compared when the acknowledge appears.
module tb_opb_register_bank;
  localparam logic [31:0] BASE = 32'h01003800;
  localparam int          NREG = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [32*NREG-1:0]   user_data_out;
  logic [NREG-1:0]      user_wr_stb;

  opb_register_bank_if bus();

  opb_register_bank #(.C_NUM_REGS(NREG)) dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst),
    .bus          (bus.slave),
    .user_data_out(user_data_out),
    .user_wr_stb  (user_wr_stb)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              tag;
    logic               err;
    logic [31:0]        dbus;
    logic [NREG-1:0]    stb;
    logic [32*NREG-1:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [NREG];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32*NREG-1:0] flat();
    logic [32*NREG-1:0] f;
    for (int i = 0; i < NREG; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  // Update the model, push the expected ACK-cycle response, drive the request
  task automatic start(input string tag, input logic [31:0] addr, input logic rnw,
                       input logic [0:3] be, input logic [31:0] wdata);
    exp_t        e;
    int          idx;
    logic [31:0] m;
    idx    = int'((addr - BASE) >> 2);
    e.tag  = tag;
    e.err  = (idx >= NREG);
    e.dbus = '0;
    e.stb  = '0;
    if (idx < NREG && !rnw) begin
      m = model[idx];
      for (int b = 0; b < 4; b++) if (be[b]) m[31-8*b -: 8] = wdata[31-8*b -: 8];
      model[idx] = m;
      if (be != 4'b0000) e.stb[idx] = 1'b1;
    end
`ifdef OPB_REGBANK_READBACK_EN
    if (idx < NREG && rnw) e.dbus = model[idx];
`endif
    e.data = flat();
    sb.push_back(e);
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_BE     = be;
    bus.OPB_DBus   = wdata;
    bus.OPB_select = 1'b1;
  endtask

  // Wait (bounded) for the acknowledge, then pop and compare
  task automatic wait_ack();
    exp_t e;
    int   waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (bus.Sl_xferAck !== 1'b1 && waited < 4);
    e = sb.pop_front();
    check({e.tag, "_latency"}, 256'(waited), 256'(1));
    check({e.tag, "_ack"}, 256'(bus.Sl_xferAck), 256'(1'b1));
    check({e.tag, "_err"}, 256'(bus.Sl_errAck), 256'(e.err));
    check({e.tag, "_dbus"}, 256'(bus.Sl_DBus), 256'(e.dbus));
    check({e.tag, "_stb"}, 256'(user_wr_stb), 256'(e.stb));
    check({e.tag, "_data"}, 256'(user_data_out), 256'(e.data));
  endtask

  // Drop select and check that the WAIT cycle is quiet, then return to IDLE
  task automatic finish_xfer(input string tag);
    bus.OPB_select = 1'b0;
    @(posedge clk); #1;
    check({tag, "_wait_ack"}, 256'(bus.Sl_xferAck), 256'(1'b0));
    check({tag, "_wait_err"}, 256'(bus.Sl_errAck), 256'(1'b0));
    check({tag, "_wait_dbus"}, 256'(bus.Sl_DBus), 256'(32'h0));
    check({tag, "_wait_stb"}, 256'(user_wr_stb), 256'(0));
    @(posedge clk); #1;
  endtask

  task automatic xfer(input string tag, input logic [31:0] addr, input logic rnw,
                      input logic [0:3] be, input logic [31:0] wdata);
    start(tag, addr, rnw, be, wdata);
    wait_ack();
    finish_xfer(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout n_assert=%0d n_fail=%0d", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_RNW     = 1'b1;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 256'(bus.Sl_xferAck), 256'(1'b0));
    check("rst_err", 256'(bus.Sl_errAck), 256'(1'b0));
    check("rst_dbus", 256'(bus.Sl_DBus), 256'(32'h0));
    check("rst_stb", 256'(user_wr_stb), 256'(0));
    check("rst_data", 256'(user_data_out), 256'(flat()));
    check("rst_retry", 256'({bus.Sl_retry, bus.Sl_toutSup}), 256'(2'b00));
    rst = 1'b0;
    @(posedge clk); #1;

    // Read of a freshly reset register
    xfer("rd_idx3", 32'h0100380C, 1'b1, 4'b1111, 32'h0);

    // Full-word write, then read back
    xfer("wr_idx2", 32'h01003808, 1'b0, 4'b1111, 32'hDEADBEEF);
    check("wr_idx2_word", 256'(user_data_out[95:64]), 256'(32'hDEADBEEF));
    xfer("rd_idx2", 32'h01003808, 1'b1, 4'b1111, 32'h0);

    // Partial byte-enable write
    xfer("wr_be0101", 32'h01003808, 1'b0, 4'b0101, 32'h11223344);
    check("be0101_word", 256'(user_data_out[95:64]), 256'(32'hDE22BE44));

    // Byte-offset address bits ignored; single MSB byte
    xfer("wr_off", 32'h01003807, 1'b0, 4'b1000, 32'hA5FFFFFF);
    check("off_word", 256'(user_data_out[63:32]), 256'(32'hA5000000));

    // Write with no byte enables: acked, no strobe, no change
    xfer("wr_be0", 32'h01003814, 1'b0, 4'b0000, 32'hFFFFFFFF);

    // Out-of-range index inside the decoded window
    xfer("wr_idx9", 32'h01003824, 1'b0, 4'b1111, 32'h12345678);
    xfer("rd_idx9", 32'h01003824, 1'b1, 4'b1111, 32'h0);

    // Addresses outside the window are never acknowledged
    bus.OPB_ABus   = 32'h01003900;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_BE     = 4'b1111;
    bus.OPB_DBus   = 32'hFFFFFFFF;
    bus.OPB_select = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("miss_high_ack", 256'(bus.Sl_xferAck), 256'(1'b0));
    end
    bus.OPB_ABus = 32'h010037FC;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("miss_low_ack", 256'(bus.Sl_xferAck), 256'(1'b0));
    end
    check("miss_data", 256'(user_data_out), 256'(flat()));
    bus.OPB_select = 1'b0;
    @(posedge clk); #1;

    // Select held after ack: one pulse only, accepted again after one low cycle
    start("hold_wr", 32'h01003810, 1'b0, 4'b1111, 32'h0BADF00D);
    wait_ack();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_ack", 256'(bus.Sl_xferAck), 256'(1'b0));
      check("hold_stb", 256'(user_wr_stb), 256'(0));
    end
    check("hold_data", 256'(user_data_out), 256'(flat()));
    bus.OPB_select = 1'b0;
    @(posedge clk); #1;
    check("hold_low_ack", 256'(bus.Sl_xferAck), 256'(1'b0));
    xfer("hold_rd", 32'h01003810, 1'b1, 4'b1111, 32'h0);

    // Reset in the ACK cycle of a write to idx 0
    start("rst_wr_idx0", 32'h01003800, 1'b0, 4'b1111, 32'hCAFEF00D);
    wait_ack();
    rst            = 1'b1;
    bus.OPB_select = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
    @(posedge clk); #1;
    check("abort_ack", 256'(bus.Sl_xferAck), 256'(1'b0));
    check("abort_err", 256'(bus.Sl_errAck), 256'(1'b0));
    check("abort_stb", 256'(user_wr_stb), 256'(0));
    check("abort_idx0", 256'(user_data_out[31:0]), 256'(32'h0));
    check("abort_data", 256'(user_data_out), 256'(flat()));
    rst = 1'b0;
    @(posedge clk); #1;
    xfer("post_rst_rd0", 32'h01003800, 1'b1, 4'b1111, 32'h0);
    xfer("post_rst_wr7", 32'h0100381C, 1'b0, 4'b0011, 32'h00005A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
